// File: rtl/speck_pkg.sv
// Shared constants, FSM encoding and rotate helpers for the Speck64/128 engine.
package speck_pkg;

   localparam int SPECK_W      = 32;
   localparam int SPECK_ROUNDS = 27;
   localparam int SPECK_ALPHA  = 8;
   localparam int SPECK_BETA   = 3;
   localparam int SPECK_CNT_W  = $clog2(SPECK_ROUNDS);

   typedef logic [SPECK_W-1:0]     word_t;
   typedef logic [SPECK_CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } speck_state_e;

   function automatic word_t ror(input word_t v, input int unsigned n);
      return (v >> n) | (v << (SPECK_W - n));
   endfunction

   function automatic word_t rol(input word_t v, input int unsigned n);
      return (v << n) | (v >> (SPECK_W - n));
   endfunction

endpackage

// File: rtl/speck_encrypt_core_if.sv
// Command/response bundle between the UART front-end and the encrypt core.
interface speck_encrypt_core_if;
   import speck_pkg::*;

   logic                 start;
   logic [4*SPECK_W-1:0] key;
   word_t                pt_x;
   word_t                pt_y;
   logic                 busy;
   logic                 done;
   word_t                ct_x;
   word_t                ct_y;
   word_t                rk_out;
   logic                 rk_valid;

   modport master (
      output start, key, pt_x, pt_y,
      input  busy, done, ct_x, ct_y, rk_out, rk_valid
   );

   modport slave (
      input  start, key, pt_x, pt_y,
      output busy, done, ct_x, ct_y, rk_out, rk_valid
   );

endinterface

// File: rtl/speck_round_forward.sv
// One combinational Speck forward round; also reused for the key-schedule step.
module speck_round_forward
   import speck_pkg::*;
(
   input  word_t x,
   input  word_t y,
   input  word_t k,
   output word_t x_next,
   output word_t y_next
);

   assign x_next = (ror(x, SPECK_ALPHA) + y) ^ k;
   assign y_next = rol(y, SPECK_BETA) ^ x_next;

endmodule

// File: rtl/speck_encrypt_core.sv
// Iterative Speck64/128 encryptor: one round per clock, key schedule expanded on the fly.
module speck_encrypt_core
   import speck_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   speck_encrypt_core_if.slave  bus
);

   speck_state_e state;
   cnt_t         cnt;
   word_t        x, y, k, l0, l1, l2;
   word_t        x_nxt, y_nxt, l_new, k_nxt;

   speck_round_forward u_round (
      .x      (x),
      .y      (y),
      .k      (k),
      .x_next (x_nxt),
      .y_next (y_nxt)
   );

   // Key step is the same round shape: l0 plays x, k plays y, the counter is the key.
   speck_round_forward u_key_step (
      .x      (l0),
      .y      (k),
      .k      (word_t'(cnt)),
      .x_next (l_new),
      .y_next (k_nxt)
   );

   // k is only advanced on non-final rounds, so it still holds the last used key afterwards.
   assign bus.rk_out = k;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values; blocking here would chain rounds within one cycle.
      if (rst) begin
         // NOTE: datapath and key registers are reset too, so no key material survives an aborted run.
         state        <= ST_IDLE;
         cnt          <= '0;
         x            <= '0;
         y            <= '0;
         k            <= '0;
         l0           <= '0;
         l1           <= '0;
         l2           <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.rk_valid <= 1'b0;
         bus.ct_x     <= '0;
         bus.ct_y     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  x            <= bus.pt_x;
                  y            <= bus.pt_y;
                  k            <= bus.key[SPECK_W-1:0];
                  l0           <= bus.key[2*SPECK_W-1:SPECK_W];
                  l1           <= bus.key[3*SPECK_W-1:2*SPECK_W];
                  l2           <= bus.key[4*SPECK_W-1:3*SPECK_W];
                  cnt          <= '0;
                  bus.busy     <= 1'b1;
                  bus.rk_valid <= 1'b1;
                  state        <= ST_RUN;
               end
            end

            ST_RUN: begin
               x <= x_nxt;
               y <= y_nxt;
               if (cnt == cnt_t'(SPECK_ROUNDS - 1)) begin
                  bus.ct_x     <= x_nxt;
                  bus.ct_y     <= y_nxt;
                  bus.rk_valid <= 1'b0;
                  bus.done     <= 1'b1;
                  state        <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
                  k   <= k_nxt;
                  l0  <= l1;
                  l1  <= l2;
                  l2  <= l_new;
               end
            end

            ST_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_speck_encrypt_core.sv
// Randomised self-checking bench for speck_encrypt_core against a loop-based Speck64/128 model.
module tb_speck_encrypt_core;

   localparam logic [127:0] KEY1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
   localparam logic [31:0]  PTX1 = 32'h3b726574;
   localparam logic [31:0]  PTY1 = 32'h7475432d;
   localparam logic [31:0]  CTX1 = 32'h8c6fa548;
   localparam logic [31:0]  CTY1 = 32'h454e028b;

   logic clk = 1'b0;
   logic rst = 1'b1;

   speck_encrypt_core_if bus ();

   speck_encrypt_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   logic [31:0] rk_q[$];
   logic [31:0] ref_rk[27];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] tror(input logic [31:0] v, input int n);
      return (v >> n) | (v << (32 - n));
   endfunction

   function automatic logic [31:0] trol(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Reference: textbook Speck with the key schedule expanded into arrays up front.
   task automatic ref_encrypt(input logic [127:0] kin, input logic [31:0] px, input logic [31:0] py,
                              output logic [31:0] cx, output logic [31:0] cy);
      logic [31:0] kk[27];
      logic [31:0] ll[29];
      kk[0] = kin[31:0];
      ll[0] = kin[63:32];
      ll[1] = kin[95:64];
      ll[2] = kin[127:96];
      for (int i = 0; i < 26; i++) begin
         ll[i+3] = (kk[i] + tror(ll[i], 8)) ^ 32'(i);
         kk[i+1] = trol(kk[i], 3) ^ ll[i+3];
      end
      cx = px;
      cy = py;
      for (int i = 0; i < 27; i++) begin
         cx = (tror(cx, 8) + cy) ^ kk[i];
         cy = trol(cy, 3) ^ cx;
      end
      ref_rk = kk;
   endtask

   always @(negedge clk) begin
      if (bus.rk_valid) rk_q.push_back(bus.rk_out);
      if (bus.done) done_cnt++;
   end

   // mode 0: plain run; 1: spurious start pulses at RUN 5/27 and DONE; 2: reset at RUN cycle 10.
   task automatic run_block(input logic [127:0] kin, input logic [31:0] px, input logic [31:0] py,
                            input int mode, output int lat);
      lat = -1;
      rk_q.delete();
      done_cnt = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.key   = kin;
      bus.pt_x  = px;
      bus.pt_y  = py;
      @(posedge clk);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.done) lat = n;
         if (mode == 1 && (n == 5 || n == 27 || n == 28)) begin
            bus.start = 1'b1;
            bus.key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.pt_x  = $urandom();
            bus.pt_y  = $urandom();
         end else begin
            bus.start = 1'b0;
         end
         if (mode == 2 && n == 10) rst = 1'b1;
         if (mode == 2 && n == 11) begin
            check("abort_busy", bus.busy, 0);
            check("abort_ct_x", bus.ct_x, 0);
            check("abort_ct_y", bus.ct_y, 0);
            check("abort_rk_valid", bus.rk_valid, 0);
            rst = 1'b0;
            repeat (40) @(negedge clk);
            check("abort_no_done", done_cnt, 0);
            lat = -2;
            break;
         end
         if (lat >= 0) break;
      end
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_stream(input string tag);
      int bad = 0;
      for (int i = 0; i < 27; i++)
         if (rk_q.size() <= i || rk_q[i] !== ref_rk[i]) bad++;
      check({tag, "_rk_count"}, rk_q.size(), 27);
      check({tag, "_rk_stream_errors"}, bad, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] ex, ey, rx, ry;
      logic [127:0] bk[3];
      logic [31:0]  bpx[3], bpy[3], bcx[3], bcy[3];
      int           blk, last;

      bus.start = 1'b0;
      bus.key   = '0;
      bus.pt_x  = '0;
      bus.pt_y  = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_rk_valid", bus.rk_valid, 0);
      check("reset_ct_x", bus.ct_x, 0);
      check("reset_ct_y", bus.ct_y, 0);
      check("reset_rk_out", bus.rk_out, 0);
      rst = 1'b0;
      @(negedge clk);

      // Published vector plus round-key stream.
      ref_encrypt(KEY1, PTX1, PTY1, ex, ey);
      check("model_ct_x", ex, CTX1);
      check("model_ct_y", ey, CTY1);
      run_block(KEY1, PTX1, PTY1, 0, lat);
      check("kat_latency", lat, 28);
      check("kat_ct_x", bus.ct_x, CTX1);
      check("kat_ct_y", bus.ct_y, CTY1);
      check("kat_rk0", rk_q.size() > 0 ? rk_q[0] : 32'hx, 32'h03020100);
      check("kat_rk1", rk_q.size() > 1 ? rk_q[1] : 32'hx, 32'h131d0309);
      check_stream("kat");
      check("kat_done_count", done_cnt, 1);
      check("kat_idle_busy", bus.busy, 0);
      check("kat_rk_hold", bus.rk_out, ref_rk[26]);

      // Inverse rounds with the captured keys in reverse order.
      rx = bus.ct_x;
      ry = bus.ct_y;
      if (rk_q.size() == 27) begin
         for (int i = 26; i >= 0; i--) begin
            ry = tror(ry ^ rx, 3);
            rx = trol((rx ^ rk_q[i]) - ry, 8);
         end
      end
      check("roundtrip_x", rx, PTX1);
      check("roundtrip_y", ry, PTY1);

      // Start pulses during RUN and DONE must be ignored.
      run_block(KEY1, PTX1, PTY1, 1, lat);
      check("ignore_latency", lat, 28);
      check("ignore_ct_x", bus.ct_x, CTX1);
      check("ignore_ct_y", bus.ct_y, CTY1);
      repeat (5) @(negedge clk);
      check("ignore_done_count", done_cnt, 1);
      check("ignore_idle_busy", bus.busy, 0);

      // Mid-run reset, then a clean restart.
      run_block(KEY1, PTX1, PTY1, 2, lat);
      check("abort_flag", lat, -2);
      run_block(KEY1, PTX1, PTY1, 0, lat);
      check("restart_latency", lat, 28);
      check("restart_ct_x", bus.ct_x, CTX1);
      check("restart_ct_y", bus.ct_y, CTY1);

      // Random vectors.
      for (int t = 0; t < 6; t++) begin
         logic [127:0] rk;
         logic [31:0]  px, py;
         rk = {$urandom(), $urandom(), $urandom(), $urandom()};
         px = $urandom();
         py = $urandom();
         ref_encrypt(rk, px, py, ex, ey);
         run_block(rk, px, py, 0, lat);
         check($sformatf("rand%0d_latency", t), lat, 28);
         check($sformatf("rand%0d_ct_x", t), bus.ct_x, ex);
         check($sformatf("rand%0d_ct_y", t), bus.ct_y, ey);
         check_stream($sformatf("rand%0d", t));
         check($sformatf("rand%0d_done_count", t), done_cnt, 1);
      end

      // Back-to-back with start held high; data switched in each DONE cycle.
      bk[0] = KEY1;
      bpx[0] = PTX1;
      bpy[0] = PTY1;
      for (int b = 1; b < 3; b++) begin
         bk[b]  = {$urandom(), $urandom(), $urandom(), $urandom()};
         bpx[b] = $urandom();
         bpy[b] = $urandom();
      end
      for (int b = 0; b < 3; b++) begin
         ref_encrypt(bk[b], bpx[b], bpy[b], ex, ey);
         bcx[b] = ex;
         bcy[b] = ey;
      end
      done_cnt = 0;
      blk = 0;
      last = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.key   = bk[0];
      bus.pt_x  = bpx[0];
      bus.pt_y  = bpy[0];
      for (int n = 1; n <= 120 && blk < 3; n++) begin
         @(negedge clk);
         if (bus.done) begin
            check($sformatf("b2b%0d_ct_x", blk), bus.ct_x, bcx[blk]);
            check($sformatf("b2b%0d_ct_y", blk), bus.ct_y, bcy[blk]);
            if (blk == 0) check("b2b_first_latency", n, 28);
            else          check($sformatf("b2b%0d_period", blk), n - last, 29);
            last = n;
            blk++;
            if (blk < 3) begin
               bus.key  = bk[blk];
               bus.pt_x = bpx[blk];
               bus.pt_y = bpy[blk];
            end else begin
               bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b_blocks", blk, 3);
      check("b2b_done_count", done_cnt, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
